// File: rtl/sanitizer_lockout_ctrl_if.sv
// Byte-forwarding handshake between the lockout controller and the core.
//   out_data   captured byte for the core
//   out_valid  out_data holds an unconsumed byte
//   out_ready  core accepts out_data this cycle
// master: controller side (drives data/valid). slave: core side (drives ready).
interface sanitizer_lockout_ctrl_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/sanitizer_lockout_ctrl.sv
// Policy controller sequencing the Citadel input sanitizer.
// Runs an escalating-lockout FSM (ARMED / HOLD / COOLDOWN) driven by sanitizer
// attack pulses and forwards changed debounced bytes to the core.
// Optional feature macro: SANITIZER_PERMALOCK_EN adds a PERMA state entered on an
// attack in HOLD/COOLDOWN at MAX_LEVEL; only rst_n leaves it.
// Ports:
//   clk        system clock, posedge
//   rst_n      synchronous active-low reset
//   attack_in  one-cycle fuzzing-threshold pulse from the sanitizer
//   san_data   debounced byte from the sanitizer
//   out_if     master side of the byte handshake (out_data/out_valid/out_ready)
//   locked     high in HOLD (and PERMA); sanitizer output must be ignored
//   level      current escalation level, 0..MAX_LEVEL
//   overrun    sticky: a pending byte was overwritten; cleared only by reset
module sanitizer_lockout_ctrl #(
   parameter int unsigned BASE_LOCKOUT = 25_000_000,
   parameter int unsigned MAX_LEVEL    = 3,
   parameter int unsigned PROBATION    = 2_500_000,
   parameter int unsigned DECAY_CYCLES = 250_000_000,
   parameter int unsigned CNT_W        = 28
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            attack_in,
   input  logic [7:0]                      san_data,
   sanitizer_lockout_ctrl_if.master        out_if,
   output logic                            locked,
   output logic [1:0]                      level,
   output logic                            overrun
);

   typedef enum logic [1:0] {
      StArmed    = 2'd0,
      StHold     = 2'd1,
`ifdef SANITIZER_PERMALOCK_EN
      StPerma    = 2'd3,
`endif
      StCooldown = 2'd2
   } state_e;

   localparam logic [1:0] MaxLvl = 2'(MAX_LEVEL);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [1:0]       level_q, level_d;
   logic [1:0]       lvl_up;
   logic [7:0]       last_fwd_q, last_fwd_d;
   logic [7:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic             overrun_q, overrun_d;
   logic             capture_ok;
   logic             escalate;

   // Last cycle index of a lockout at the given level.
   function automatic logic [CNT_W-1:0] lock_last(input logic [1:0] lvl);
      return (CNT_W'(BASE_LOCKOUT) << lvl) - CNT_W'(1);
   endfunction

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      level_d    = level_q;
      last_fwd_d = last_fwd_q;
      data_d     = data_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;
      capture_ok = 1'b0;
      escalate   = 1'b0;
      lvl_up     = (level_q == MaxLvl) ? level_q : level_q + 2'd1;

      case (state_q)
         StArmed: begin
            if (attack_in) begin
               // Attack also wins over a coincident decay expiry: no decrement.
               state_d = StHold;
               timer_d = lock_last(level_q);
            end else begin
               capture_ok = 1'b1;
               if (timer_q == CNT_W'(DECAY_CYCLES - 1)) begin
                  timer_d = '0;
                  if (level_q != 2'd0) level_d = level_q - 2'd1;
               end else begin
                  timer_d = timer_q + CNT_W'(1);
               end
            end
         end
         StHold: begin
            if (attack_in) begin
               escalate = 1'b1;
            end else if (timer_q == '0) begin
               state_d = StCooldown;
               timer_d = CNT_W'(PROBATION - 1);
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         StCooldown: begin
            if (attack_in) begin
               escalate = 1'b1;
            end else begin
               capture_ok = 1'b1;
               if (timer_q == '0) begin
                  state_d = StArmed;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q - CNT_W'(1);
               end
            end
         end
`ifdef SANITIZER_PERMALOCK_EN
         StPerma: begin
            // Terminal until reset: no captures, timer frozen.
         end
`endif
         default: begin
            state_d = StArmed;
            timer_d = '0;
         end
      endcase

      if (escalate) begin
`ifdef SANITIZER_PERMALOCK_EN
         if (level_q == MaxLvl) begin
            state_d = StPerma;
         end else begin
            state_d = StHold;
            level_d = lvl_up;
            timer_d = lock_last(lvl_up);
         end
`else
         state_d = StHold;
         level_d = lvl_up;
         timer_d = lock_last(lvl_up);
`endif
      end

      // Capture wins over a same-cycle handshake; overwrite of a stalled byte is sticky.
      if (capture_ok && (san_data != last_fwd_q)) begin
         data_d     = san_data;
         last_fwd_d = san_data;
         valid_d    = 1'b1;
         if (valid_q && !out_if.out_ready) overrun_d = 1'b1;
      end else if (valid_q && out_if.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StArmed;
         timer_q    <= '0;
         level_q    <= 2'd0;
         last_fwd_q <= 8'h00;
         data_q     <= 8'h00;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         level_q    <= level_d;
         last_fwd_q <= last_fwd_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

`ifdef SANITIZER_PERMALOCK_EN
   assign locked = (state_q == StHold) || (state_q == StPerma);
`else
   assign locked = (state_q == StHold);
`endif
   assign level            = level_q;
   assign overrun          = overrun_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_valid = valid_q;

endmodule
